// File: rtl/fmc_adc_pattern_gen_if.sv
// Parallel ADC sample bus plus control strobes for the synthetic ADC source.
// The rand_en member exists only when ADC_RAND_EN is defined.
interface fmc_adc_pattern_gen_if;
    logic        arm;
    logic        stop;
    logic        trigger;
    logic        continuous;
    logic [1:0]  mode;
    logic [15:0] fixed_word;
    logic [7:0]  rate_div;
    logic [15:0] burst_len;
`ifdef ADC_RAND_EN
    logic        rand_en;
`endif
    logic [15:0] adc_data_out;
    logic        adc_ov_out;
    logic        adc_valid;
    logic        busy;
    logic        done;

`ifdef ADC_RAND_EN
    modport master (
        input  arm, stop, trigger, continuous, mode, fixed_word, rate_div, burst_len, rand_en,
        output adc_data_out, adc_ov_out, adc_valid, busy, done
    );
    modport slave (
        output arm, stop, trigger, continuous, mode, fixed_word, rate_div, burst_len, rand_en,
        input  adc_data_out, adc_ov_out, adc_valid, busy, done
    );
`else
    modport master (
        input  arm, stop, trigger, continuous, mode, fixed_word, rate_div, burst_len,
        output adc_data_out, adc_ov_out, adc_valid, busy, done
    );
    modport slave (
        output arm, stop, trigger, continuous, mode, fixed_word, rate_div, burst_len,
        input  adc_data_out, adc_ov_out, adc_valid, busy, done
    );
`endif
endinterface

// File: rtl/fmc_adc_pattern_gen.sv
// Synthetic LTC-style ADC sample source: ramp / fixed / alternate / LFSR words, burst or continuous.
// Optional output randomizer (rand_en input) is built only when ADC_RAND_EN is defined.
module fmc_adc_pattern_gen #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [15:0] RAMP_STEP = 16'd1
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    fmc_adc_pattern_gen_if.master         bus
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;

    logic [1:0]  mode_q, mode_d;
    logic [15:0] fixed_q, fixed_d;
    logic [7:0]  rate_q, rate_d;
    logic [15:0] len_q, len_d;
    logic        cont_q, cont_d;
`ifdef ADC_RAND_EN
    logic        rand_q, rand_d;
`endif

    logic [7:0]  div_q, div_d;
    logic [16:0] cnt_q, cnt_d;
    logic [15:0] ramp_q, ramp_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        phase_q, phase_d;
    logic [15:0] data_q, data_d;
    logic        ov_q, ov_d;
    logic        valid_q, valid_d;

    logic        arm_accept;
    logic [16:0] burst_target;
    logic        burst_end;
    logic        strobe;
    logic        lfsr_fb;
    logic [15:0] word;
    logic [15:0] out_word;
    logic        busy;
    logic        done;

    // burst_len of zero stands for a full 65536-sample burst, hence the 17-bit count
    assign arm_accept   = (state_q == S_IDLE) && bus.arm && !bus.stop;
    assign burst_target = (len_q == 16'd0) ? 17'h10000 : {1'b0, len_q};
    assign burst_end    = !cont_q && (cnt_q == burst_target);
    assign strobe       = (state_q == S_RUN) && (div_q == 8'd0) && !burst_end && !bus.stop;
    assign lfsr_fb      = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // State register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop always wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arm_accept) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (bus.trigger || cont_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (burst_end && valid_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_ARMED: busy = 1'b1;
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_comb begin
        mode_d  = mode_q;
        fixed_d = fixed_q;
        rate_d  = rate_q;
        len_d   = len_q;
        cont_d  = cont_q;
`ifdef ADC_RAND_EN
        rand_d  = rand_q;
`endif
        if (arm_accept) begin
            mode_d  = bus.mode;
            fixed_d = bus.fixed_word;
            rate_d  = bus.rate_div;
            len_d   = bus.burst_len;
            cont_d  = bus.continuous;
`ifdef ADC_RAND_EN
            rand_d  = bus.rand_en;
`endif
        end
    end

    // Divider held at zero while ARMED so the first RUN cycle strobes
    always_comb begin
        div_d = div_q;
        if (state_q == S_ARMED) begin
            div_d = 8'd0;
        end else if (state_q == S_RUN) begin
            div_d = (div_q == rate_q) ? 8'd0 : div_q + 8'd1;
        end
    end

    always_comb begin
        case (mode_q)
            2'd0:    word = ramp_q;
            2'd1:    word = fixed_q;
            2'd2:    word = phase_q ? ~fixed_q : fixed_q;
            default: word = lfsr_q;
        endcase
        out_word = word;
`ifdef ADC_RAND_EN
        if (rand_q) begin
            out_word = {word[15:1] ^ {15{word[0]}}, word[0]};
        end
`endif
    end

    always_comb begin
        cnt_d   = cnt_q;
        ramp_d  = ramp_q;
        lfsr_d  = lfsr_q;
        phase_d = phase_q;
        data_d  = data_q;
        ov_d    = ov_q;
        valid_d = strobe;
        if (arm_accept) begin
            cnt_d   = 17'd0;
            ramp_d  = 16'd0;
            lfsr_d  = LFSR_SEED;
            phase_d = 1'b0;
        end else if (strobe) begin
            cnt_d   = cnt_q + 17'd1;
            ramp_d  = ramp_q + RAMP_STEP;
            lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
            phase_d = ~phase_q;
            data_d  = out_word;
            ov_d    = (word == 16'h7FFF) || (word == 16'h8000);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            mode_q  <= 2'd0;
            fixed_q <= 16'd0;
            rate_q  <= 8'd0;
            len_q   <= 16'd0;
            cont_q  <= 1'b0;
            div_q   <= 8'd0;
            cnt_q   <= 17'd0;
            ramp_q  <= 16'd0;
            lfsr_q  <= LFSR_SEED;
            phase_q <= 1'b0;
            data_q  <= 16'd0;
            ov_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            fixed_q <= fixed_d;
            rate_q  <= rate_d;
            len_q   <= len_d;
            cont_q  <= cont_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            ramp_q  <= ramp_d;
            lfsr_q  <= lfsr_d;
            phase_q <= phase_d;
            data_q  <= data_d;
            ov_q    <= ov_d;
            valid_q <= valid_d;
        end
    end

`ifdef ADC_RAND_EN
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rand_q <= 1'b0;
        end else begin
            rand_q <= rand_d;
        end
    end
`endif

    assign bus.adc_data_out = data_q;
    assign bus.adc_ov_out   = ov_q;
    assign bus.adc_valid    = valid_q;
    assign bus.busy         = busy;
    assign bus.done         = done;

endmodule

// File: tb/tb_fmc_adc_pattern_gen.sv
// Directed bench for fmc_adc_pattern_gen: burst vector table plus stop/priority and full-wrap sequences.
module tb_fmc_adc_pattern_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fmc_adc_pattern_gen_if bus_if ();

    fmc_adc_pattern_gen #(
        .LFSR_SEED(16'hACE1),
        .RAMP_STEP(16'd1)
    ) dut (
        .sys_clk(clk),
        .rst    (rst),
        .bus    (bus_if)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]       mode;
        logic [15:0]      fw;
        logic [7:0]       rd;
        logic [15:0]      bl;
        logic             rnd;
        logic [2:0]       n;
        logic [3:0][15:0] exp_d;
        logic [3:0]       exp_ov;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] mode, input logic [15:0] fw, input logic [7:0] rd,
                                input logic [15:0] bl, input logic rnd, input int n,
                                input logic [15:0] d0, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [15:0] d3, input logic [3:0] ov);
        vec_t v;
        v.mode = mode; v.fw = fw; v.rd = rd; v.bl = bl; v.rnd = rnd; v.n = 3'(n);
        v.exp_d[0] = d0; v.exp_d[1] = d1; v.exp_d[2] = d2; v.exp_d[3] = d3;
        v.exp_ov = ov;
        return v;
    endfunction

    task automatic set_cfg(input logic [1:0] mode, input logic [15:0] fw, input logic [7:0] rd,
                           input logic [15:0] bl, input logic cont, input logic rnd);
        bus_if.mode       = mode;
        bus_if.fixed_word = fw;
        bus_if.rate_div   = rd;
        bus_if.burst_len  = bl;
        bus_if.continuous = cont;
`ifdef ADC_RAND_EN
        bus_if.rand_en    = rnd;
`else
        if (rnd) $display("note: randomizer not built, rand_en ignored");
`endif
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int per, last_t, done_t, got, bad_valid, bad_hold, bad_done, done_ok;
        logic [15:0] held;
        logic exp_v;
        per = int'(v.rd) + 1;
        last_t = 2 + (int'(v.n) - 1) * per;
        done_t = last_t + 1;
        got = 0; bad_valid = 0; bad_hold = 0; bad_done = 0; done_ok = 0; held = 16'h0;
        @(posedge clk); #1;
        set_cfg(v.mode, v.fw, v.rd, v.bl, 1'b0, v.rnd);
        bus_if.arm = 1'b1;
        @(posedge clk); #1;
        bus_if.arm = 1'b0;
        check($sformatf("v%0d_busy_armed", idx), 32'(bus_if.busy), 32'd1);
        bus_if.trigger = 1'b1;
        @(posedge clk); #1;
        bus_if.trigger = 1'b0;
        for (int t = 1; t <= done_t + 2; t++) begin
            if (t > 1) begin
                @(posedge clk); #1;
            end
            exp_v = (t >= 2) && (t <= last_t) && (((t - 2) % per) == 0);
            if (bus_if.adc_valid !== exp_v) bad_valid++;
            if (bus_if.adc_valid === 1'b1 && exp_v && got < int'(v.n)) begin
                check($sformatf("v%0d_data%0d", idx, got), 32'(bus_if.adc_data_out), 32'(v.exp_d[got]));
                check($sformatf("v%0d_ov%0d", idx, got), 32'(bus_if.adc_ov_out), 32'(v.exp_ov[got]));
                held = bus_if.adc_data_out;
                got++;
            end else if (got > 0 && bus_if.adc_data_out !== held) begin
                bad_hold++;
            end
            if (bus_if.done === 1'b1) begin
                if (t == done_t) done_ok = 1;
                else bad_done++;
            end
        end
        check($sformatf("v%0d_valid_timing", idx), 32'(bad_valid), 32'd0);
        check($sformatf("v%0d_sample_count", idx), 32'(got), 32'(v.n));
        check($sformatf("v%0d_hold", idx), 32'(bad_hold), 32'd0);
        check($sformatf("v%0d_done_pulse", idx), 32'(done_ok + 2 * bad_done), 32'd1);
        check($sformatf("v%0d_busy_after", idx), 32'(bus_if.busy), 32'd0);
    endtask

    initial begin
        int cnt, bad_d, bad_ov, ov_cnt, done_after, prev_v, done_prev_v, hits, extra;
        logic [15:0] last;

        rst = 1'b1;
        bus_if.arm = 1'b0; bus_if.stop = 1'b0; bus_if.trigger = 1'b0;
        set_cfg(2'd0, 16'h0, 8'd0, 16'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_data",  32'(bus_if.adc_data_out), 32'd0);
        check("rst_ov",    32'(bus_if.adc_ov_out),   32'd0);
        check("rst_valid", 32'(bus_if.adc_valid),    32'd0);
        check("rst_busy",  32'(bus_if.busy),         32'd0);
        check("rst_done",  32'(bus_if.done),         32'd0);

        vecs.push_back(mk(2'd0, 16'h0000, 8'd0, 16'd4, 1'b0, 4, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 4'b0000));
        vecs.push_back(mk(2'd0, 16'h0000, 8'd3, 16'd3, 1'b0, 3, 16'h0000, 16'h0001, 16'h0002, 16'h0000, 4'b0000));
        vecs.push_back(mk(2'd3, 16'h0000, 8'd0, 16'd3, 1'b0, 3, 16'hACE1, 16'h5670, 16'hAB38, 16'h0000, 4'b0000));
        vecs.push_back(mk(2'd2, 16'h5555, 8'd0, 16'd3, 1'b0, 3, 16'h5555, 16'hAAAA, 16'h5555, 16'h0000, 4'b0000));
        vecs.push_back(mk(2'd1, 16'h7FFF, 8'd1, 16'd2, 1'b0, 2, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 4'b0011));
        vecs.push_back(mk(2'd2, 16'h8000, 8'd0, 16'd2, 1'b0, 2, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 4'b0011));
        vecs.push_back(mk(2'd1, 16'h1234, 8'd2, 16'd1, 1'b0, 1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 4'b0000));
`ifdef ADC_RAND_EN
        vecs.push_back(mk(2'd0, 16'h0000, 8'd0, 16'd3, 1'b1, 3, 16'h0000, 16'hFFFF, 16'h0002, 16'h0000, 4'b0000));
        vecs.push_back(mk(2'd3, 16'h0000, 8'd0, 16'd1, 1'b1, 1, 16'h531F, 16'h0000, 16'h0000, 16'h0000, 4'b0000));
`endif
        foreach (vecs[i]) run_vec(vecs[i], i);

        // Continuous run cut by stop after the tenth sample
        @(posedge clk); #1;
        set_cfg(2'd0, 16'h0, 8'd0, 16'd2, 1'b1, 1'b0);
        bus_if.arm = 1'b1;
        @(posedge clk); #1;
        bus_if.arm = 1'b0;
        cnt = 0;
        for (int t = 0; t < 50 && cnt < 10; t++) begin
            @(posedge clk); #1;
            if (bus_if.adc_valid === 1'b1) cnt++;
        end
        check("stop_valids_before", 32'(cnt), 32'd10);
        bus_if.stop = 1'b1;
        @(posedge clk); #1;
        bus_if.stop = 1'b0;
        hits = 0; extra = 0;
        for (int t = 0; t < 20; t++) begin
            if (bus_if.adc_valid === 1'b1) hits++;
            if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) extra++;
            @(posedge clk); #1;
        end
        check("stop_no_valid", 32'(hits), 32'd0);
        check("stop_no_done_busy", 32'(extra), 32'd0);
        check("stop_data_held", 32'(bus_if.adc_data_out), 32'd9);

        // stop together with arm, then a trigger while IDLE
        set_cfg(2'd0, 16'h0, 8'd0, 16'd2, 1'b0, 1'b0);
        bus_if.arm = 1'b1; bus_if.stop = 1'b1;
        @(posedge clk); #1;
        bus_if.arm = 1'b0; bus_if.stop = 1'b0;
        extra = 0;
        for (int t = 0; t < 4; t++) begin
            if (bus_if.busy !== 1'b0) extra++;
            @(posedge clk); #1;
        end
        check("stop_arm_idle", 32'(extra), 32'd0);
        bus_if.trigger = 1'b1;
        @(posedge clk); #1;
        bus_if.trigger = 1'b0;
        extra = 0;
        for (int t = 0; t < 6; t++) begin
            if (bus_if.adc_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) extra++;
            @(posedge clk); #1;
        end
        check("trigger_idle_quiet", 32'(extra), 32'd0);

        // Full 65536-sample ramp burst with wrap and overrange points
        set_cfg(2'd0, 16'h0, 8'd0, 16'd0, 1'b0, 1'b0);
        bus_if.arm = 1'b1;
        @(posedge clk); #1;
        bus_if.arm = 1'b0; bus_if.trigger = 1'b1;
        @(posedge clk); #1;
        bus_if.trigger = 1'b0;
        cnt = 0; bad_d = 0; bad_ov = 0; ov_cnt = 0; done_after = -1; prev_v = 0; done_prev_v = 0;
        last = 16'h0;
        for (int t = 0; t < 70000; t++) begin
            @(posedge clk); #1;
            if (bus_if.done === 1'b1) begin
                done_after = cnt;
                done_prev_v = prev_v;
                break;
            end
            prev_v = 0;
            if (bus_if.adc_valid === 1'b1) begin
                if (bus_if.adc_data_out !== cnt[15:0]) bad_d++;
                if (bus_if.adc_ov_out !== ((cnt[15:0] == 16'h7FFF) || (cnt[15:0] == 16'h8000))) bad_ov++;
                if (bus_if.adc_ov_out === 1'b1) ov_cnt++;
                last = bus_if.adc_data_out;
                cnt++;
                prev_v = 1;
            end
        end
        check("wrap_count", 32'(cnt), 32'd65536);
        check("wrap_last", 32'(last), 32'h0000FFFF);
        check("wrap_data_seq", 32'(bad_d), 32'd0);
        check("wrap_ov_seq", 32'(bad_ov), 32'd0);
        check("wrap_ov_hits", 32'(ov_cnt), 32'd2);
        check("wrap_done_after", 32'(done_after), 32'd65536);
        check("wrap_done_follows_valid", 32'(done_prev_v), 32'd1);
        @(posedge clk); #1;
        check("wrap_idle_after", 32'(bus_if.busy | bus_if.done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
